// File: rtl/jt900h_flags_if.sv
// ALU-to-flag-register bundle: ALU results, write controls and condition query in,
// current flag sets, ALU feedback and condition result out.
interface jt900h_flags_if;
  logic       alu_s;
  logic       alu_z;
  logic       alu_h;
  logic       alu_v;
  logic       alu_n;
  logic       alu_c;
  logic [5:0] flag_we;
  logic [1:0] cf_op;
  logic       ldf;
  logic [7:0] din;
  logic       ex_ff;
  logic [3:0] cc;
  logic [7:0] flags;
  logic [7:0] flags_x;
  logic       nin;
  logic       hin;
  logic       cin;
  logic       zin;
  logic       cc_ok;

  modport master (
    output alu_s, alu_z, alu_h, alu_v, alu_n, alu_c, flag_we, cf_op, ldf, din, ex_ff, cc,
    input  flags, flags_x, nin, hin, cin, zin, cc_ok
  );

  modport slave (
    input  alu_s, alu_z, alu_h, alu_v, alu_n, alu_c, flag_we, cf_op, ldf, din, ex_ff, cc,
    output flags, flags_x, nin, hin, cin, zin, cc_ok
  );
endinterface

// File: rtl/jt900h_flags.sv
// TLCS-900H flag register F and alternate set F': masked ALU capture, carry ops,
// load/exchange, and condition-code evaluation from the registered F.
module jt900h_flags #(
  parameter logic [7:0] F_RST  = 8'h00,
  parameter logic [7:0] FX_RST = 8'h00
) (
  input logic            clk,
  input logic            rst_n,
  input logic            cen,
  jt900h_flags_if.slave  bus
);

  // Bits 5 and 3 do not exist in F and always read as zero.
  localparam logic [7:0] FMask = 8'hD7;

  logic [7:0] f_q, f_d;
  logic [7:0] fx_q, fx_d;
  logic       s_m, z_m, h_m, v_m, n_m, c_m;
  logic       h_new, n_new, c_new;
  logic       cc_base;

  always_comb begin
    s_m = bus.flag_we[5] ? bus.alu_s : f_q[7];
    z_m = bus.flag_we[4] ? bus.alu_z : f_q[6];
    h_m = bus.flag_we[3] ? bus.alu_h : f_q[4];
    v_m = bus.flag_we[2] ? bus.alu_v : f_q[2];
    n_m = bus.flag_we[1] ? bus.alu_n : f_q[1];
    c_m = bus.flag_we[0] ? bus.alu_c : f_q[0];

    h_new = h_m;
    n_new = n_m;
    c_new = c_m;
    // Carry ops apply on top of the masked ALU result.
    unique case (bus.cf_op)
      2'd1: begin c_new = 1'b0;  h_new = 1'b0; n_new = 1'b0; end
      2'd2: begin c_new = 1'b1;  h_new = 1'b0; n_new = 1'b0; end
      2'd3: begin c_new = ~c_m;  h_new = c_m;  n_new = 1'b0; end
      default: ;
    endcase
  end

  always_comb begin
    f_d  = f_q;
    fx_d = fx_q;
    if (bus.ldf) begin
      f_d = bus.din & FMask;
    end else if (bus.ex_ff) begin
      f_d  = fx_q;
      fx_d = f_q;
    end else begin
      f_d = {s_m, z_m, 1'b0, h_new, 1'b0, v_m, n_new, c_new};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q  <= F_RST & FMask;
      fx_q <= FX_RST & FMask;
    end else if (cen) begin
      f_q  <= f_d;
      fx_q <= fx_d;
    end
  end

  // Codes 8-F are the complements of codes 0-7.
  always_comb begin
    cc_base = 1'b0;
    unique case (bus.cc[2:0])
      3'd0: cc_base = 1'b0;
      3'd1: cc_base = f_q[7] ^ f_q[2];
      3'd2: cc_base = (f_q[7] ^ f_q[2]) | f_q[6];
      3'd3: cc_base = f_q[0] | f_q[6];
      3'd4: cc_base = f_q[2];
      3'd5: cc_base = f_q[7];
      3'd6: cc_base = f_q[6];
      3'd7: cc_base = f_q[0];
      default: cc_base = 1'b0;
    endcase
  end

  assign bus.cc_ok   = cc_base ^ bus.cc[3];
  assign bus.flags   = f_q;
  assign bus.flags_x = fx_q;
  assign bus.nin     = f_q[1];
  assign bus.hin     = f_q[4];
  assign bus.cin     = f_q[0];
  assign bus.zin     = f_q[6];

endmodule
